exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/interrupt request controller that drives the CP0 exception interface.
- Collects external interrupt lines and decoded trap instructions (syscall, break, teq), prioritises them, and raises exception with cause at committed instruction boundaries.
- Passes eret through to CP0.
- Tracks in-handler state so nested requests are held off, and flags traps taken inside a handler.

Parameters:
- NUM_IRQ, 6, number of external interrupt lines (1..8).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- irq  input  NUM_IRQ  raw asynchronous external interrupt lines, rising-edge significant
- irq_mask  input  NUM_IRQ  per-line enable; 1 = line may be dispatched
- ie  input  1  global interrupt enable (CP0 Status[0])
- pend_clr  input  NUM_IRQ  software clear of pending bits, one cycle per bit
- instr_valid  input  1  current instruction commits this cycle (instruction boundary)
- syscall  input  1  current instruction is syscall (qualified by instr_valid)
- brk  input  1  current instruction is break (qualified by instr_valid)
- teq_trap  input  1  current instruction is teq with equal operands (qualified by instr_valid)
- eret_in  input  1  current instruction is eret (qualified by instr_valid)
- exception  output  1  exception request to CP0, combinational, one cycle
- cause  output  5  ExcCode to CP0; valid when exception=1, else 0
- eret  output  1  eret request to CP0, combinational, one cycle
- irq_id  output  3  index of the last dispatched interrupt line, registered
- pending  output  NUM_IRQ  registered pending bits
- in_handler  output  1  1 while in state HANDLER
- double_fault  output  1  sticky; trap requested while in HANDLER

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE; pending=0; synchroniser and edge flops=0; irq_id=0; double_fault=0.
  - Reset overrides every other input that cycle.
  - Reset mid-handler returns to IDLE.
- Input path:
  - irq[i] passes through a 2-flop synchroniser, then an edge-detect flop.
  - Rising edge (sync2=1, sync2_d=0) sets pending[i].
  - Latency: irq[i] first sampled high at edge k -> pending[i]=1 after edge k+2.
  - A level held high sets pending only once.
- Pending update, per bit, per edge:
  - Set by edge detect has priority over pend_clr (no lost edges).
  - Otherwise pend_clr[i] clears the bit.
  - Otherwise the bit is cleared when line i is dispatched.
- Cause codes:
  - interrupt = 0
  - syscall = 8
  - break = 9
  - teq = 13
- Priority, highest first: syscall > brk > teq_trap > interrupt.
  - Among interrupts, the lowest index of (pending & irq_mask) wins.
- State IDLE:
  - If instr_valid and any trap input is set: exception=1, cause per priority, next state HANDLER.
  - Else if instr_valid, ie=1 and |(pending & irq_mask):
    - exception=1, cause=0.
    - irq_id <= winning index; pending[winner] cleared at this edge.
    - Next state HANDLER.
  - No instr_valid: no exception; requests wait. Interrupts are never taken mid-instruction.
- State HANDLER:
  - exception held 0 and interrupts are not dispatched; pending keeps accumulating.
  - instr_valid with any trap input: double_fault <= 1 (sticky until reset); state unchanged.
  - instr_valid & eret_in: eret=1, next state IDLE.
- eret output:
  - eret = instr_valid & eret_in & ~exception in any state.
  - In IDLE, eret passes through and state stays IDLE.
  - If exception and eret_in occur together, exception wins and eret is suppressed.
- cause=0 whenever exception=0. Outputs are stable within a cycle and have no combinational path from irq.
- in_handler = (state==HANDLER).

Test Plan:
- Reset, then syscall=1, instr_valid=1 for one cycle -> exception=1, cause=8 that cycle; in_handler=1 next cycle; a second syscall -> exception=0, double_fault=1.
- irq[2] rises, irq_mask=6'b111111, ie=1, instr_valid=1 continuously -> pending[2]=1 after edge k+2; exception=1, cause=0 the following cycle; irq_id=2; pending[2]=0 next cycle.
- irq[4] and irq[1] rise together, mask=6'b010000 -> line 4 dispatched (irq_id=4); pending[1] remains 1.
- In HANDLER, irq[0] rises -> pending[0]=1, no exception; eret_in=1, instr_valid=1 -> eret=1, state IDLE; next valid cycle exception=1, cause=0, irq_id=0.
- ie=0 with pending[3]=1 -> no exception for 10 cycles. pend_clr[3] on the same edge as a new irq[3] edge -> pending[3] stays 1.
- Hold reset=0 while in HANDLER with pending=6'b000101 -> next cycle in_handler=0, pending=0, double_fault=0, irq_id=0.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception/interrupt request controller feeding the CP0 exception interface.
// Synchronises external interrupt lines, latches their rising edges as pending
// bits, and raises one exception per committed instruction boundary, with traps
// taking precedence over interrupts. A single HANDLER state holds off nesting.
module exc_ctrl #(
  parameter int NUM_IRQ = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               ie,
  input  logic [NUM_IRQ-1:0] pend_clr,
  input  logic               instr_valid,
  input  logic               syscall,
  input  logic               brk,
  input  logic               teq_trap,
  input  logic               eret_in,
  output logic               exception,
  output logic [4:0]         cause,
  output logic               eret,
  output logic [2:0]         irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_handler,
  output logic               double_fault
);

  localparam logic [4:0] CAUSE_INT     = 5'd0;
  localparam logic [4:0] CAUSE_SYSCALL = 5'd8;
  localparam logic [4:0] CAUSE_BREAK   = 5'd9;
  localparam logic [4:0] CAUSE_TEQ     = 5'd13;

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;
  logic [NUM_IRQ-1:0] r_sync2_d;
  logic [NUM_IRQ-1:0] r_pending;
  logic [2:0]         r_irq_id;
  logic               r_double_fault;

  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_req;
  logic [2:0]         w_win_idx;
  logic               w_trap;
  logic               w_dispatch;
  logic               w_exception;
  logic [4:0]         w_cause;
  logic               w_set_df;

  assign w_edge = r_sync2 & ~r_sync2_d;
  assign w_req  = r_pending & irq_mask;
  assign w_trap = instr_valid & (syscall | brk | teq_trap);

  // Lowest-index enabled pending line wins; scan downwards so the last hit is the lowest.
  always_comb begin
    w_win_idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) w_win_idx = 3'(i);
    end
  end

  // Next-state and exception request decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_exception = 1'b0;
    w_cause     = CAUSE_INT;
    w_dispatch  = 1'b0;
    w_set_df    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trap) begin
          w_exception = 1'b1;
          w_state_nxt = HANDLER;
          if (syscall)  w_cause = CAUSE_SYSCALL;
          else if (brk) w_cause = CAUSE_BREAK;
          else          w_cause = CAUSE_TEQ;
        end else if (instr_valid && ie && (|w_req)) begin
          w_exception = 1'b1;
          w_dispatch  = 1'b1;
          w_state_nxt = HANDLER;
        end
      end
      HANDLER: begin
        if (w_trap) w_set_df = 1'b1;
        if (instr_valid && eret_in) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // A reset cycle presents nothing to CP0.
    if (!reset) begin
      w_exception = 1'b0;
      w_dispatch  = 1'b0;
      w_set_df    = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  // State register plus synchroniser, edge detector and sticky double-fault flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!reset) begin
      r_state        <= IDLE;
      r_sync1        <= '0;
      r_sync2        <= '0;
      r_sync2_d      <= '0;
      r_double_fault <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sync1   <= irq;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      if (w_set_df) r_double_fault <= 1'b1;
    end
  end

  // Pending bits: a fresh edge beats a software clear, which beats a dispatch clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= '0;
      r_irq_id  <= 3'd0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (w_edge[i])                                 r_pending[i] <= 1'b1;
        else if (pend_clr[i])                          r_pending[i] <= 1'b0;
        else if (w_dispatch && (w_win_idx == 3'(i)))   r_pending[i] <= 1'b0;
      end
      if (w_dispatch) r_irq_id <= w_win_idx;
    end
  end

  assign exception    = w_exception;
  assign cause        = w_exception ? w_cause : 5'd0;
  assign eret         = reset & instr_valid & eret_in & ~w_exception;
  assign irq_id       = r_irq_id;
  assign pending      = r_pending;
  assign in_handler   = (r_state == HANDLER);
  assign double_fault = r_double_fault;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl. Stimulus pushes the expected CP0 request
// (exception+cause or eret) into a queue; a monitor pops and compares each time
// the DUT raises a request, and flags any request nobody expected.
module tb_exc_ctrl;

  localparam int N = 6;

  typedef struct packed {
    logic       is_eret;
    logic [4:0] cause;
  } req_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq, irq_mask, pend_clr, pending;
  logic         ie, instr_valid, syscall, brk, teq_trap, eret_in;
  logic         exception, eret, in_handler, double_fault;
  logic [4:0]   cause;
  logic [2:0]   irq_id;

  int   total = 0;
  int   bad   = 0;
  req_t exp_q[$];

  exc_ctrl #(.NUM_IRQ(N)) dut (
    .clk(clk), .reset(reset), .irq(irq), .irq_mask(irq_mask), .ie(ie),
    .pend_clr(pend_clr), .instr_valid(instr_valid), .syscall(syscall),
    .brk(brk), .teq_trap(teq_trap), .eret_in(eret_in),
    .exception(exception), .cause(cause), .eret(eret), .irq_id(irq_id),
    .pending(pending), .in_handler(in_handler), .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_eret, input logic [4:0] c);
    req_t r;
    r.is_eret = is_eret;
    r.cause   = c;
    exp_q.push_back(r);
  endtask

  task automatic do_eret();
    instr_valid = 1'b1;
    eret_in     = 1'b1;
    push(1'b1, 5'd0);
    tick();
    eret_in = 1'b0;
  endtask

  // Monitor: compare every request the DUT presents against the queue head.
  always @(negedge clk) begin
    if (exception || eret) begin
      if (exp_q.size() == 0) begin
        check("unexpected_request", {30'd0, exception, eret}, 32'd0);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        check("req_is_eret", 32'(eret), 32'(e.is_eret));
        check("req_is_exc", 32'(exception), 32'(!e.is_eret));
        if (!e.is_eret) check("req_cause", 32'(cause), 32'(e.cause));
      end
    end else begin
      if (cause != 5'd0) check("cause_idle_zero", 32'(cause), 32'd0);
    end
  end

  initial begin
    reset = 1'b0; irq = '0; irq_mask = '0; pend_clr = '0; ie = 1'b0;
    instr_valid = 1'b0; syscall = 1'b0; brk = 1'b0; teq_trap = 1'b0; eret_in = 1'b0;
    tick(); tick();
    check("rst_in_handler", 32'(in_handler), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    check("rst_double_fault", 32'(double_fault), 32'd0);
    reset = 1'b1;

    // Syscall, then a second syscall inside the handler.
    instr_valid = 1'b1; syscall = 1'b1; push(1'b0, 5'd8);
    tick();
    check("sys_in_handler", 32'(in_handler), 32'd1);
    check("sys2_no_exc", 32'(exception), 32'd0);
    tick();
    check("sys2_double_fault", 32'(double_fault), 32'd1);
    syscall = 1'b0;
    do_eret();
    check("sys_eret_idle", 32'(in_handler), 32'd0);

    // irq[2] edge with continuous instruction commits.
    ie = 1'b1; irq_mask = 6'b111111; instr_valid = 1'b1;
    irq = 6'b000100;
    tick(); tick();
    check("irq2_pending_k1", 32'(pending), 32'd0);
    tick();
    check("irq2_pending_k2", 32'(pending), 32'b000100);
    push(1'b0, 5'd0);
    tick();
    check("irq2_irq_id", 32'(irq_id), 32'd2);
    check("irq2_pending_clr", 32'(pending), 32'd0);
    check("irq2_in_handler", 32'(in_handler), 32'd1);
    do_eret();
    check("irq2_back_idle", 32'(in_handler), 32'd0);

    // irq[4] and irq[1] together, only line 4 enabled; irq[2] level held (no re-set).
    irq_mask = 6'b010000;
    irq = 6'b010110;
    tick(); tick(); tick();
    check("irq41_pending", 32'(pending), 32'b010010);
    push(1'b0, 5'd0);
    tick();
    check("irq41_irq_id", 32'(irq_id), 32'd4);
    check("irq41_pending_after", 32'(pending), 32'b000010);

    // irq[0] accumulates in HANDLER, then is taken right after eret.
    irq_mask = 6'b111111;
    irq = 6'b010111;
    tick(); tick(); tick();
    check("hnd_pending", 32'(pending), 32'b000011);
    check("hnd_no_exc", 32'(exception), 32'd0);
    check("hnd_in_handler", 32'(in_handler), 32'd1);
    do_eret();
    push(1'b0, 5'd0);
    tick();
    check("irq0_irq_id", 32'(irq_id), 32'd0);
    check("irq0_pending", 32'(pending), 32'b000010);
    pend_clr = 6'b000010;
    tick();
    pend_clr = '0;
    check("pend_clr_1", 32'(pending), 32'd0);
    do_eret();
    instr_valid = 1'b0;
    check("irq0_back_idle", 32'(in_handler), 32'd0);

    // Trap priority, and exception suppressing a simultaneous eret.
    instr_valid = 1'b1; brk = 1'b1; teq_trap = 1'b1; push(1'b0, 5'd9);
    tick();
    brk = 1'b0; teq_trap = 1'b0;
    do_eret();
    teq_trap = 1'b1; push(1'b0, 5'd13);
    tick();
    teq_trap = 1'b0;
    do_eret();
    syscall = 1'b1; brk = 1'b1; eret_in = 1'b1; push(1'b0, 5'd8);
    tick();
    check("exc_beats_eret", 32'(in_handler), 32'd1);
    syscall = 1'b0; brk = 1'b0;
    do_eret();

    // ie=0 holds off a pending line; edge beats pend_clr on the same edge.
    ie = 1'b0;
    irq = 6'b011111;
    tick(); tick(); tick();
    check("ie0_pending", 32'(pending), 32'b001000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ie0_no_exc", 32'(exception), 32'd0);
    end
    irq = 6'b010111;
    tick(); tick(); tick();
    irq = 6'b011111;
    tick(); tick();
    pend_clr = 6'b001000;
    tick();
    check("edge_beats_clr", 32'(pending), 32'b001000);
    tick();
    pend_clr = '0;
    check("clr_after_edge", 32'(pending), 32'd0);

    // Reset while in HANDLER with pending bits set.
    irq = '0;
    tick(); tick(); tick();
    syscall = 1'b1; push(1'b0, 5'd8);
    tick();
    syscall = 1'b0; instr_valid = 1'b0;
    irq = 6'b000101;
    tick(); tick(); tick();
    check("pre_rst_pending", 32'(pending), 32'b000101);
    check("pre_rst_in_handler", 32'(in_handler), 32'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_in_handler", 32'(in_handler), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_double_fault", 32'(double_fault), 32'd0);
    check("mid_rst_irq_id", 32'(irq_id), 32'd0);
    reset = 1'b1; irq = '0;
    tick(); tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
